// File: rtl/wav_dfi_lp_pkg.sv
// Shared types and default timing for the DFI low-power handshake engine.
package wav_dfi_lp_pkg;

  // Per-channel handshake state.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    ACTIVE = 3'd2,
    EXIT   = 3'd3,
    ABORT  = 3'd4
  } lp_state_e;

  // Default timing constants, in DFI clock cycles.
  localparam int TLP_RESP_DEF     = 8;
  localparam int EXIT_TIMEOUT_DEF = 16;
  localparam int HOLDOFF_DEF      = 4;
  localparam int WAKEUP_W_DEF     = 6;

  // Width of the shared per-channel counter: it must hold the largest of the three limits.
  function automatic int lp_cnt_w(input int tlp, input int exit_to, input int holdoff);
    int m;
    m = tlp;
    if (exit_to > m) m = exit_to;
    if (holdoff > m) m = holdoff;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/wav_dfi_lp_chan.sv
// One DFI low-power channel: turns a level host request into a legal req/ack handshake.
//
// Handshake: req_o is raised only from IDLE with ack_i low. Once req_o is high it stays high
// until the PHY acks (low power entered), the host withdraws, or TLP_RESP cycles pass without
// ack (abort). After req_o falls, the channel waits for ack_i to fall before it may request
// again. An ack seen while no request is outstanding is a protocol error.
module wav_dfi_lp_chan
  import wav_dfi_lp_pkg::*;
#(
  parameter int TLP_RESP     = TLP_RESP_DEF,
  parameter int EXIT_TIMEOUT = EXIT_TIMEOUT_DEF,
  parameter int HOLDOFF      = HOLDOFF_DEF,
  parameter int WAKEUP_W     = WAKEUP_W_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                host_req_i,
  input  logic [WAKEUP_W-1:0] host_wakeup_i,
  input  logic                gate_i,
  input  logic                init_start_i,
  input  logic                ack_i,
  output logic                req_o,
  output logic [WAKEUP_W-1:0] wakeup_o,
  output logic                lp_active_o,
  output logic                denied_o,
  output logic                perr_o,
  output lp_state_e           state_o
);

  localparam int CNT_W = lp_cnt_w(TLP_RESP, EXIT_TIMEOUT, HOLDOFF);

  // REQ: last unacked cycle allowed; EXIT: ack-high cycles tolerated; ABORT: idle cycles reloaded.
  localparam logic [CNT_W-1:0] TLP_LAST = CNT_W'(TLP_RESP - 1);
  localparam logic [CNT_W-1:0] EXIT_MAX = CNT_W'(EXIT_TIMEOUT);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLDOFF);

  lp_state_e           state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                req_q;
  logic [WAKEUP_W-1:0] wakeup_q;
  logic                lp_active_q;
  logic                denied_q;
  logic                perr_q;

  // Channel FSM; the counter is reused as holdoff (IDLE), response timer (REQ) and exit timer (EXIT).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      wakeup_q    <= '0;
      lp_active_q <= 1'b0;
      denied_q    <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      denied_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          if (ack_i) begin
            // Ack with no request outstanding: flag it and hold off until it drops.
            perr_q <= 1'b1;
          end else if (host_req_i && !init_start_i && !gate_i && (cnt_q == '0)) begin
            state_q  <= REQ;
            req_q    <= 1'b1;
            wakeup_q <= host_wakeup_i;
            cnt_q    <= '0;
          end
        end
        REQ: begin
          if (ack_i) begin
            // Ack wins even on the final allowed cycle.
            state_q     <= ACTIVE;
            lp_active_q <= 1'b1;
          end else if (!host_req_i) begin
            state_q <= EXIT;
            req_q   <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q == TLP_LAST) begin
            state_q  <= ABORT;
            req_q    <= 1'b0;
            denied_q <= 1'b1;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ACTIVE: begin
          if (!host_req_i || !ack_i) begin
            // Ack dropping while req is still high is a PHY protocol violation.
            if (!ack_i) perr_q <= 1'b1;
            state_q     <= EXIT;
            req_q       <= 1'b0;
            lp_active_q <= 1'b0;
            cnt_q       <= '0;
          end
        end
        EXIT: begin
          if (!ack_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == EXIT_MAX) begin
            // Counter saturates here; error stays set while we keep waiting.
            perr_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ABORT: begin
          if (ack_i) begin
            // Late ack after the abort: release it like a normal exit, no error.
            state_q <= EXIT;
            cnt_q   <= '0;
          end else begin
            state_q <= IDLE;
            cnt_q   <= HOLD_LD;
          end
        end
        default: begin
          state_q     <= IDLE;
          cnt_q       <= '0;
          req_q       <= 1'b0;
          lp_active_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_o       = req_q;
  assign wakeup_o    = wakeup_q;
  assign lp_active_o = lp_active_q;
  assign denied_o    = denied_q;
  assign perr_o      = perr_q;
  assign state_o     = state_q;

endmodule

// File: rtl/wav_dfi_lp_ctrl.sv
// MC-side DFI low-power handshake engine: independent ctrl and data channels toward the PHY.
module wav_dfi_lp_ctrl
  import wav_dfi_lp_pkg::*;
#(
  parameter int TLP_RESP     = TLP_RESP_DEF,
  parameter int EXIT_TIMEOUT = EXIT_TIMEOUT_DEF,
  parameter int HOLDOFF      = HOLDOFF_DEF,
  parameter int WAKEUP_W     = WAKEUP_W_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                host_ctrl_req,
  input  logic [WAKEUP_W-1:0] host_ctrl_wakeup,
  input  logic                host_data_req,
  input  logic [WAKEUP_W-1:0] host_data_wakeup,
  input  logic                cmd_busy,
  input  logic                rw_busy,
  input  logic                init_start,
  input  logic                dfi_lp_ctrl_ack,
  input  logic                dfi_lp_data_ack,
  output logic                dfi_lp_ctrl_req,
  output logic [WAKEUP_W-1:0] dfi_lp_ctrl_wakeup,
  output logic                dfi_lp_data_req,
  output logic [WAKEUP_W-1:0] dfi_lp_data_wakeup,
  output logic                ctrl_lp_active,
  output logic                data_lp_active,
  output logic                ctrl_denied,
  output logic                data_denied,
  output logic [1:0]          proto_err,
  output lp_state_e           ctrl_state_o,
  output lp_state_e           data_state_o
);

  logic ctrl_perr;
  logic data_perr;

  // Ctrl channel is blocked from entry while any command address phase is active.
  wav_dfi_lp_chan #(
    .TLP_RESP     (TLP_RESP),
    .EXIT_TIMEOUT (EXIT_TIMEOUT),
    .HOLDOFF      (HOLDOFF),
    .WAKEUP_W     (WAKEUP_W)
  ) u_ctrl (
    .clk_i         (clock),
    .rst_i         (reset),
    .host_req_i    (host_ctrl_req),
    .host_wakeup_i (host_ctrl_wakeup),
    .gate_i        (cmd_busy),
    .init_start_i  (init_start),
    .ack_i         (dfi_lp_ctrl_ack),
    .req_o         (dfi_lp_ctrl_req),
    .wakeup_o      (dfi_lp_ctrl_wakeup),
    .lp_active_o   (ctrl_lp_active),
    .denied_o      (ctrl_denied),
    .perr_o        (ctrl_perr),
    .state_o       (ctrl_state_o)
  );

  // Data channel is blocked from entry while any read/write data phase is active.
  wav_dfi_lp_chan #(
    .TLP_RESP     (TLP_RESP),
    .EXIT_TIMEOUT (EXIT_TIMEOUT),
    .HOLDOFF      (HOLDOFF),
    .WAKEUP_W     (WAKEUP_W)
  ) u_data (
    .clk_i         (clock),
    .rst_i         (reset),
    .host_req_i    (host_data_req),
    .host_wakeup_i (host_data_wakeup),
    .gate_i        (rw_busy),
    .init_start_i  (init_start),
    .ack_i         (dfi_lp_data_ack),
    .req_o         (dfi_lp_data_req),
    .wakeup_o      (dfi_lp_data_wakeup),
    .lp_active_o   (data_lp_active),
    .denied_o      (data_denied),
    .perr_o        (data_perr),
    .state_o       (data_state_o)
  );

  assign proto_err = {data_perr, ctrl_perr};

endmodule

// File: tb/tb_wav_dfi_lp_ctrl.sv
// Directed bench for the DFI low-power handshake engine.
module tb_wav_dfi_lp_ctrl;
  import wav_dfi_lp_pkg::*;

  localparam int WW = 6;

  logic          clock = 1'b0;
  logic          reset;
  logic          host_ctrl_req;
  logic [WW-1:0] host_ctrl_wakeup;
  logic          host_data_req;
  logic [WW-1:0] host_data_wakeup;
  logic          cmd_busy;
  logic          rw_busy;
  logic          init_start;
  logic          dfi_lp_ctrl_ack;
  logic          dfi_lp_data_ack;
  logic          dfi_lp_ctrl_req;
  logic [WW-1:0] dfi_lp_ctrl_wakeup;
  logic          dfi_lp_data_req;
  logic [WW-1:0] dfi_lp_data_wakeup;
  logic          ctrl_lp_active;
  logic          data_lp_active;
  logic          ctrl_denied;
  logic          data_denied;
  logic [1:0]    proto_err;
  lp_state_e     ctrl_state_o;
  lp_state_e     data_state_o;

  int checks   = 0;
  int failures = 0;

  logic [WW-1:0] ctrl_exp_q[$];
  logic [WW-1:0] data_exp_q[$];

  wav_dfi_lp_ctrl #(
    .TLP_RESP     (8),
    .EXIT_TIMEOUT (16),
    .HOLDOFF      (4),
    .WAKEUP_W     (WW)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .host_ctrl_req      (host_ctrl_req),
    .host_ctrl_wakeup   (host_ctrl_wakeup),
    .host_data_req      (host_data_req),
    .host_data_wakeup   (host_data_wakeup),
    .cmd_busy           (cmd_busy),
    .rw_busy            (rw_busy),
    .init_start         (init_start),
    .dfi_lp_ctrl_ack    (dfi_lp_ctrl_ack),
    .dfi_lp_data_ack    (dfi_lp_data_ack),
    .dfi_lp_ctrl_req    (dfi_lp_ctrl_req),
    .dfi_lp_ctrl_wakeup (dfi_lp_ctrl_wakeup),
    .dfi_lp_data_req    (dfi_lp_data_req),
    .dfi_lp_data_wakeup (dfi_lp_data_wakeup),
    .ctrl_lp_active     (ctrl_lp_active),
    .data_lp_active     (data_lp_active),
    .ctrl_denied        (ctrl_denied),
    .data_denied        (data_denied),
    .proto_err          (proto_err),
    .ctrl_state_o       (ctrl_state_o),
    .data_state_o       (data_state_o)
  );

  // Clock and watchdog
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_ctrl(input string tag);
    if (ctrl_exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      check(tag, 32'(dfi_lp_ctrl_wakeup), 32'(ctrl_exp_q.pop_front()));
    end
  endtask

  task automatic pop_data(input string tag);
    if (data_exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      check(tag, 32'(dfi_lp_data_wakeup), 32'(data_exp_q.pop_front()));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_creq"}, 32'(dfi_lp_ctrl_req), 0);
    check({tag, "_cwk"},  32'(dfi_lp_ctrl_wakeup), 0);
    check({tag, "_dreq"}, 32'(dfi_lp_data_req), 0);
    check({tag, "_dwk"},  32'(dfi_lp_data_wakeup), 0);
    check({tag, "_cact"}, 32'(ctrl_lp_active), 0);
    check({tag, "_dact"}, 32'(data_lp_active), 0);
    check({tag, "_cden"}, 32'(ctrl_denied), 0);
    check({tag, "_dden"}, 32'(data_denied), 0);
    check({tag, "_perr"}, 32'(proto_err), 0);
    check({tag, "_cst"},  32'(ctrl_state_o), 32'(IDLE));
    check({tag, "_dst"},  32'(data_state_o), 32'(IDLE));
  endtask

  initial begin
    int  n;
    logic seen;

    reset            = 1'b1;
    host_ctrl_req    = 1'b0;
    host_ctrl_wakeup = '0;
    host_data_req    = 1'b0;
    host_data_wakeup = '0;
    cmd_busy         = 1'b0;
    rw_busy          = 1'b0;
    init_start       = 1'b0;
    dfi_lp_ctrl_ack  = 1'b0;
    dfi_lp_data_ack  = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // Ctrl entry with ack after 3 req cycles; wakeup frozen while active.
    host_ctrl_req    = 1'b1;
    host_ctrl_wakeup = 6'd5;
    ctrl_exp_q.push_back(6'd5);
    tick();
    check("t1_req_rise", 32'(dfi_lp_ctrl_req), 1);
    pop_ctrl("t1_wakeup");
    tick();
    tick();
    check("t1_not_active_yet", 32'(ctrl_lp_active), 0);
    dfi_lp_ctrl_ack = 1'b1;
    tick();
    check("t1_active", 32'(ctrl_lp_active), 1);
    check("t1_state", 32'(ctrl_state_o), 32'(ACTIVE));
    host_ctrl_wakeup = 6'd9;
    tick();
    tick();
    check("t1_wakeup_frozen", 32'(dfi_lp_ctrl_wakeup), 5);
    check("t1_req_held", 32'(dfi_lp_ctrl_req), 1);
    check("t1_no_perr", 32'(proto_err), 0);
    check("t1_data_quiet", 32'(dfi_lp_data_req), 0);

    // Host drops while ack stays high for 20 cycles: exit timeout after 16.
    host_ctrl_req = 1'b0;
    tick();
    check("t4_req_fall", 32'(dfi_lp_ctrl_req), 0);
    check("t4_active_fall", 32'(ctrl_lp_active), 0);
    for (int i = 0; i < 15; i++) tick();
    check("t4_perr_not_yet", 32'(proto_err), 0);
    for (int i = 0; i < 4; i++) tick();
    check("t4_perr_set", 32'(proto_err), 32'h1);
    check("t4_state_exit", 32'(ctrl_state_o), 32'(EXIT));
    dfi_lp_ctrl_ack = 1'b0;
    tick();
    check("t4_idle", 32'(ctrl_state_o), 32'(IDLE));
    check("t4_perr_sticky", 32'(proto_err), 32'h1);

    // Data request gated by rw_busy for 10 cycles, rises the cycle after release.
    rw_busy          = 1'b1;
    host_data_req    = 1'b1;
    host_data_wakeup = 6'd7;
    data_exp_q.push_back(6'd7);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_gated", 32'(dfi_lp_data_req), 0);
    end
    rw_busy = 1'b0;
    tick();
    check("t3_req_rise", 32'(dfi_lp_data_req), 1);
    pop_data("t3_wakeup");
    dfi_lp_data_ack = 1'b1;
    tick();
    check("t3_active", 32'(data_lp_active), 1);

    // init_start blocks ctrl entry; cmd_busy after issue does not retract req.
    init_start       = 1'b1;
    host_ctrl_req    = 1'b1;
    host_ctrl_wakeup = 6'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_init_block", 32'(dfi_lp_ctrl_req), 0);
    end
    init_start = 1'b0;
    ctrl_exp_q.push_back(6'd3);
    tick();
    check("t5_req_rise", 32'(dfi_lp_ctrl_req), 1);
    pop_ctrl("t5_wakeup");
    cmd_busy = 1'b1;
    tick();
    check("t5_no_retract", 32'(dfi_lp_ctrl_req), 1);
    cmd_busy        = 1'b0;
    dfi_lp_ctrl_ack = 1'b1;
    tick();
    check("t5_ctrl_active", 32'(ctrl_lp_active), 1);
    check("t5_data_active", 32'(data_lp_active), 1);
    check("t5_perr_before", 32'(proto_err), 32'h1);

    // Reset while both channels are active.
    reset = 1'b1;
    tick();
    check_all_zero("t5_reset");
    host_ctrl_req    = 1'b0;
    host_data_req    = 1'b0;
    host_ctrl_wakeup = '0;
    dfi_lp_ctrl_ack  = 1'b0;
    dfi_lp_data_ack  = 1'b0;
    reset            = 1'b0;
    tick();

    // Data request never acked: 8 req cycles, denied pulse, holdoff, then re-request.
    host_data_req    = 1'b1;
    host_data_wakeup = 6'h2A;
    data_exp_q.push_back(6'h2A);
    tick();
    check("t2_req_rise", 32'(dfi_lp_data_req), 1);
    pop_data("t2_wakeup");
    n = 1;
    for (int i = 0; i < 20 && dfi_lp_data_req; i++) begin
      tick();
      if (dfi_lp_data_req) n++;
    end
    check("t2_req_cycles", 32'(n), 8);
    check("t2_req_low", 32'(dfi_lp_data_req), 0);
    check("t2_denied", 32'(data_denied), 1);
    check("t2_no_ctrl_denied", 32'(ctrl_denied), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_holdoff_req", 32'(dfi_lp_data_req), 0);
      check("t2_denied_pulse", 32'(data_denied), 0);
    end
    data_exp_q.push_back(6'h2A);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (dfi_lp_data_req) seen = 1'b1;
    end
    check("t2_rereq", 32'(seen), 1);
    pop_data("t2_rereq_wakeup");
    check("t2_no_perr", 32'(proto_err), 0);
    host_data_req = 1'b0;
    tick();
    check("t2_withdraw", 32'(dfi_lp_data_req), 0);
    tick();
    check("t2_idle", 32'(data_state_o), 32'(IDLE));

    // Spurious ack in IDLE: error, no request until ack drops.
    dfi_lp_data_ack = 1'b1;
    tick();
    tick();
    check("t6_perr", 32'(proto_err), 32'h2);
    host_data_req    = 1'b1;
    host_data_wakeup = 6'h11;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_blocked", 32'(dfi_lp_data_req), 0);
    end
    dfi_lp_data_ack = 1'b0;
    data_exp_q.push_back(6'h11);
    tick();
    check("t6_req_rise", 32'(dfi_lp_data_req), 1);
    pop_data("t6_wakeup");

    // Ack arriving on the last allowed cycle wins over the abort.
    for (int i = 0; i < 7; i++) begin
      tick();
      check("tb_req_held", 32'(dfi_lp_data_req), 1);
    end
    dfi_lp_data_ack = 1'b1;
    tick();
    check("tb_late_active", 32'(data_lp_active), 1);
    check("tb_late_req", 32'(dfi_lp_data_req), 1);
    check("tb_late_denied", 32'(data_denied), 0);
    host_data_req = 1'b0;
    tick();
    check("tb_exit_req", 32'(dfi_lp_data_req), 0);
    dfi_lp_data_ack = 1'b0;
    tick();
    check("tb_exit_idle", 32'(data_state_o), 32'(IDLE));
    check("tb_perr_final", 32'(proto_err), 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
